pulse_blinker: RTL and testbench
================================

PULSE_BLINKER -- requirements
Module: pulse_blinker

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 10000000, number of clk cycles y is high per blink (>=1).
REQ-002 SHALL have parameter GAP_CYC, default 10000000, number of clk cycles y is low between blinks (>=1).
REQ-003 SHALL have parameter CNT_W, default 28, width of the hold/gap timer; 2^CNT_W > max(HOLD_CYC, GAP_CYC).
REQ-004 SHALL have parameter PEND_W, default 4, width of the pending-event counter.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port x  input  1  single-cycle event pulse from a debounce/pulse-sync stage; each high cycle is one event.
REQ-008 SHALL have port y  output  1  registered, human-visible blink output.
REQ-009 SHALL have port busy  output  1  high when the FSM is not in IDLE.
REQ-010 SHALL have port pend  output  PEND_W  count of queued, not-yet-started events.
REQ-011 SHALL have port ovf  output  1  sticky flag; an event was dropped.

Function
REQ-012 SHALL implement FSM states IDLE, ON and OFF, with a single timer of CNT_W bits.
REQ-013 SHALL define a start opportunity as any edge in IDLE, or the edge ending the last OFF cycle (timer == GAP_CYC-1).
REQ-014 SHALL, at a start opportunity with x=1 or pend!=0, enter ON, clear the timer and set y=1 after that edge; otherwise enter or remain in IDLE with y=0.
REQ-015 SHALL, at a start opportunity with pend!=0, consume one queued event (pend-1); if x=1 on the same edge, pend is unchanged (net zero).
REQ-016 SHALL, at a start opportunity with pend==0 and x=1, start that event directly without changing pend.
REQ-017 SHALL hold y=1 for exactly HOLD_CYC cycles in ON, then enter OFF with the timer cleared and y=0.
REQ-018 SHALL hold y=0 for exactly GAP_CYC cycles in OFF before the next start opportunity.
REQ-019 SHALL increment pend on any edge where x=1 and the event is not started or consumed under REQ-015/016.
REQ-020 SHALL saturate pend at 2^PEND_W-1; an increment attempted at saturation leaves pend unchanged and sets ovf=1.
REQ-021 SHALL keep ovf set until rst and never clear it by any other means.
REQ-022 SHALL register y, busy and pend, producing no combinational path from x to any output.
REQ-023 SHALL count one event per high cycle of x; x held high for k cycles equals k events.
REQ-024 SHALL produce blink-to-blink start spacing of exactly HOLD_CYC+GAP_CYC cycles while the queue is non-empty.

Reset
REQ-025 SHALL, on rst=1 and independent of clk, force IDLE, timer=0, y=0, busy=0, pend=0 and ovf=0.
REQ-026 SHALL abort any blink or queue on rst mid-ON or mid-OFF; y drops immediately and no queued event survives.
REQ-027 SHALL, on the first edge after rst deasserts, behave as IDLE; x=1 on that edge starts a blink.
REQ-028 SHALL initialise all registers to the reset values at configuration time (simulation starts defined before any rst).

Verification (HOLD_CYC=4, GAP_CYC=3, PEND_W=2)
REQ-029 SHALL verify the single pulse: one x pulse in IDLE -> y=1 for exactly 4 cycles then 0; busy high for 7 cycles; pend stays 0; back to IDLE.
REQ-030 SHALL verify queuing: 3 pulses 1 cycle apart -> 3 blinks with starts 7 cycles apart; pend peaks at 2 and decrements at each start; ends at 0.
REQ-031 SHALL verify simultaneous events: x=1 on the OFF terminal edge with pend=1 -> new blink starts and pend stays 1.
REQ-032 SHALL verify overflow: 5 pulses during one ON -> pend saturates at 3, ovf=1, exactly 4 blinks total; ovf remains 1 afterwards.
REQ-033 SHALL verify mid-blink reset: rst asserted during cycle 2 of ON with pend=2 -> y, busy, pend and ovf go to 0 without a clk edge; no further blinks.
REQ-034 SHALL verify held input: x high for 2 consecutive cycles in IDLE -> 2 blinks, pend peaks at 1.

Source files
------------

// File: rtl/pulse_blinker.sv
// Turns single-cycle event pulses into human-visible blinks of fixed on/off length.
// Events arriving while a blink is in progress are queued in a saturating counter.
module pulse_blinker #(
  parameter int HOLD_CYC = 10000000,
  parameter int GAP_CYC  = 10000000,
  parameter int CNT_W    = 28,
  parameter int PEND_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  output logic              y,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  // Declaration initialisers give defined state at configuration time, before any rst.
  state_t            state     = IDLE;
  logic [CNT_W-1:0]  timer     = '0;
  logic              y_reg     = 1'b0;
  logic              busy_reg  = 1'b0;
  logic [PEND_W-1:0] pend_reg  = '0;
  logic              ovf_reg   = 1'b0;

  state_t            state_nxt;
  logic [CNT_W-1:0]  timer_nxt;
  logic              y_nxt;
  logic              busy_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              start_opp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      y_reg    <= 1'b0;
      busy_reg <= 1'b0;
      pend_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      y_reg    <= y_nxt;
      busy_reg <= busy_nxt;
      pend_reg <= pend_nxt;
      ovf_reg  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    y_nxt     = y_reg;
    pend_nxt  = pend_reg;
    ovf_nxt   = ovf_reg;
    start_opp = (state == IDLE) || ((state == OFF) && (timer == GAP_LAST));

    if (start_opp) begin
      timer_nxt = '0;
      if ((pend_reg != '0) || x) begin
        state_nxt = ON;
        y_nxt     = 1'b1;
        // A queued event starts first; a simultaneous new event takes its queue slot.
        if ((pend_reg != '0) && !x) begin
          pend_nxt = pend_reg - 1'b1;
        end
      end else begin
        state_nxt = IDLE;
        y_nxt     = 1'b0;
      end
    end else begin
      if ((state == ON) && (timer == HOLD_LAST)) begin
        state_nxt = OFF;
        timer_nxt = '0;
        y_nxt     = 1'b0;
      end
      if (x) begin
        if (pend_reg == PEND_MAX) begin
          ovf_nxt = 1'b1;
        end else begin
          pend_nxt = pend_reg + 1'b1;
        end
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  assign y    = y_reg;
  assign busy = busy_reg;
  assign pend = pend_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker (HOLD=4, GAP=3, PEND_W=2); expected blink starts are
// queued by the stimulus and checked by an independent monitor on each rising y.
module tb_pulse_blinker;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic       y;
  logic       busy;
  logic [1:0] pend;
  logic       ovf;

  pulse_blinker #(
    .HOLD_CYC(4),
    .GAP_CYC (3),
    .CNT_W   (4),
    .PEND_W  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .busy(busy),
    .pend(pend),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int pend;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   now;
  int   s;
  int   busy_cnt;
  int   pend_max;
  logic abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input int p);
    exp_t e;
    e.cyc  = c;
    e.pend = p;
    sb.push_back(e);
  endtask

  task automatic clear_track();
    busy_cnt = 0;
    pend_max = 0;
  endtask

  // Sample outputs mid-cycle, then drive x for the next rising edge.
  task automatic step(input logic xv);
    @(negedge clk);
    now = cyc;
    if (busy) busy_cnt++;
    if (int'(pend) > pend_max) pend_max = int'(pend);
    x = xv;
  endtask

  // Monitor: every blink start must match the head of the scoreboard.
  logic y_prev = 1'b0;
  int   hi_len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (y && !y_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_blink_at_cycle", cyc, -1);
      end else begin
        e = sb.pop_front();
        check("blink_start_cycle", cyc, e.cyc);
        check("pend_at_blink_start", int'(pend), e.pend);
      end
    end
    if (!y && y_prev && !abort) check("blink_hold_len", hi_len, 4);
    hi_len = y ? (y_prev ? hi_len + 1 : 1) : 0;
    y_prev = y;
  end

  initial begin
    rst = 1'b0;
    x   = 1'b0;
    #1;
    check("init_y", int'(y), 0);
    check("init_busy", int'(busy), 0);
    check("init_pend", int'(pend), 0);
    check("init_ovf", int'(ovf), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_y", int'(y), 0);
    rst = 1'b0;

    // Single pulse in IDLE
    clear_track();
    step(1'b1);
    s = now + 1;
    push(s, 0);
    repeat (20) step(1'b0);
    check("single_busy_cycles", busy_cnt, 7);
    check("single_pend_max", pend_max, 0);
    check("single_back_idle", int'(busy), 0);

    // Three pulses one cycle apart queue up
    clear_track();
    step(1'b1);
    s = now + 1;
    push(s, 0);
    push(s + 7, 1);
    push(s + 14, 0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    repeat (25) step(1'b0);
    check("queue_pend_max", pend_max, 2);
    check("queue_pend_end", int'(pend), 0);
    check("queue_busy_end", int'(busy), 0);
    check("queue_ovf", int'(ovf), 0);

    // New event on the OFF terminal edge with one queued
    clear_track();
    step(1'b1);
    s = now + 1;
    push(s, 0);
    push(s + 7, 1);
    push(s + 14, 0);
    step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    step(1'b0);
    check("simul_pend_after_start", int'(pend), 1);
    repeat (25) step(1'b0);
    check("simul_pend_end", int'(pend), 0);
    check("simul_busy_end", int'(busy), 0);

    // Five events in one ON: saturation and sticky overflow
    clear_track();
    step(1'b1);
    s = now + 1;
    push(s, 0);
    push(s + 7, 2);
    push(s + 14, 1);
    push(s + 21, 0);
    repeat (4) step(1'b1);
    step(1'b0);
    check("ovf_pend_sat", int'(pend), 3);
    check("ovf_set", int'(ovf), 1);
    repeat (35) step(1'b0);
    check("ovf_pend_max", pend_max, 3);
    check("ovf_sticky", int'(ovf), 1);
    check("ovf_busy_end", int'(busy), 0);

    // Reset mid-ON with two queued; ovf is still set from above
    clear_track();
    step(1'b1);
    s = now + 1;
    push(s, 0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("pre_rst_pend", int'(pend), 2);
    check("pre_rst_y", int'(y), 1);
    abort = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_y", int'(y), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_pend", int'(pend), 0);
    check("async_rst_ovf", int'(ovf), 0);
    repeat (2) step(1'b0);

    // First edge after reset release carries x held for two cycles
    @(negedge clk);
    rst   = 1'b0;
    abort = 1'b0;
    now   = cyc;
    s     = now + 1;
    push(s, 0);
    push(s + 7, 0);
    clear_track();
    x = 1'b1;
    step(1'b1);
    repeat (25) step(1'b0);
    check("held_pend_max", pend_max, 1);
    check("held_pend_end", int'(pend), 0);
    check("held_busy_end", int'(busy), 0);
    check("no_blink_after_rst_abort", busy_cnt, 14);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
